// File: rtl/uart_tx_framer.sv
// uart_tx_framer
// Serialises one data word per valid/ready handshake into a UART frame:
// start bit, 5..MAX_DATA_W data bits LSB first, optional parity, 1 or 2 stop
// bits. One bit is shifted out per baud_tick interval.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line high, tx_ready=1, waiting for tx_valid
// START  | start bit (0) on tx_out
// DATA   | data bits, LSB first, bit_cnt counts the bit being sent
// PARITY | parity bit on tx_out
// STOP   | stop bit(s) high, stop_cnt counts the stop bits sent
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   baud_tick       one-clk pulse ending each bit period
//   tx_data         word to send (bits above the configured length ignored)
//   tx_valid        tx_data / cfg_* valid
//   tx_ready        framer idle and able to accept a word
//   cfg_data_len    data bits per frame (clamped to 5..MAX_DATA_W on accept)
//   cfg_parity      00 none, 01 odd, 10 even, 11 mark
//   cfg_stop2       0 one stop bit, 1 two stop bits
//   tx_out          serial line, idles high
//   busy            frame in progress
//   baud_restart    one-clk pulse on accept to realign the baud generator
//   frame_done      one-clk pulse when the last stop bit ends
module uart_tx_framer #(
    parameter int MAX_DATA_W = 9,
    parameter int LEN_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  baud_tick,
    input  logic [MAX_DATA_W-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [LEN_W-1:0]      cfg_data_len,
    input  logic [1:0]            cfg_parity,
    input  logic                  cfg_stop2,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  baud_restart,
    output logic                  frame_done
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic [MAX_DATA_W-1:0] sh_q, sh_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [1:0]            par_mode_q, par_mode_d;
    logic                  par_bit_q, par_bit_d;
    logic                  stop2_q, stop2_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  tx_out_d, tx_ready_d, busy_d;
    logic                  baud_restart_d, frame_done_d;

    logic [LEN_W-1:0]      len_c;
    logic [MAX_DATA_W-1:0] masked_c;
    logic                  par_c;

    // Clamped length and parity of the incoming word, used only at accept.
    // Parity covers just the bits that will actually be sent.
    always_comb begin
        len_c = cfg_data_len;
        if (cfg_data_len < LEN_W'(5))
            len_c = LEN_W'(5);
        else if (cfg_data_len > LEN_W'(MAX_DATA_W))
            len_c = LEN_W'(MAX_DATA_W);

        masked_c = '0;
        for (int i = 0; i < MAX_DATA_W; i++)
            if (i < int'(len_c))
                masked_c[i] = tx_data[i];

        case (cfg_parity)
            2'b01:   par_c = ~^masked_c;
            2'b10:   par_c = ^masked_c;
            2'b11:   par_c = 1'b1;
            default: par_c = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        sh_d           = sh_q;
        len_d          = len_q;
        bit_cnt_d      = bit_cnt_q;
        par_mode_d     = par_mode_q;
        par_bit_d      = par_bit_q;
        stop2_d        = stop2_q;
        stop_cnt_d     = stop_cnt_q;
        tx_out_d       = tx_out;
        tx_ready_d     = tx_ready;
        busy_d         = busy;
        baud_restart_d = 1'b0;
        frame_done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                tx_out_d   = 1'b1;
                tx_ready_d = 1'b1;
                busy_d     = 1'b0;
                if (tx_valid && tx_ready) begin
                    state_d        = START;
                    sh_d           = masked_c;
                    len_d          = len_c;
                    par_mode_d     = cfg_parity;
                    par_bit_d      = par_c;
                    stop2_d        = cfg_stop2;
                    tx_out_d       = 1'b0;
                    tx_ready_d     = 1'b0;
                    busy_d         = 1'b1;
                    baud_restart_d = 1'b1;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    tx_out_d  = sh_q[0];
                    sh_d      = sh_q >> 1;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == len_q - 1'b1) begin
                        if (par_mode_q != 2'b00) begin
                            state_d  = PARITY;
                            tx_out_d = par_bit_q;
                        end else begin
                            state_d    = STOP;
                            stop_cnt_d = 1'b0;
                            tx_out_d   = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_out_d  = sh_q[0];
                        sh_d      = sh_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                    tx_out_d   = 1'b1;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d      = IDLE;
                        tx_out_d     = 1'b1;
                        busy_d       = 1'b0;
                        tx_ready_d   = 1'b1;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                tx_out_d   = 1'b1;
                tx_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sh_q         <= '0;
            len_q        <= LEN_W'(5);
            bit_cnt_q    <= '0;
            par_mode_q   <= 2'b00;
            par_bit_q    <= 1'b0;
            stop2_q      <= 1'b0;
            stop_cnt_q   <= 1'b0;
            tx_out       <= 1'b1;
            tx_ready     <= 1'b1;
            busy         <= 1'b0;
            baud_restart <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            len_q        <= len_d;
            bit_cnt_q    <= bit_cnt_d;
            par_mode_q   <= par_mode_d;
            par_bit_q    <= par_bit_d;
            stop2_q      <= stop2_d;
            stop_cnt_q   <= stop_cnt_d;
            tx_out       <= tx_out_d;
            tx_ready     <= tx_ready_d;
            busy         <= busy_d;
            baud_restart <= baud_restart_d;
            frame_done   <= frame_done_d;
        end
    end

endmodule
